// File: rtl/reg_frame_loader.sv
// Serial-to-parallel loader: shifts 16-bit command words (header, data) MSB first and
// presents them to the neuron register bank with setup/strobe/hold sequencing.
module reg_frame_loader #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_en_i,
    input  logic       ser_valid_i,
    input  logic       ser_bit_i,
    output logic [7:0] data_in_o,
    output logic [7:0] neuron_select_o,
    output logic [1:0] select_o,
    output logic       set_data_in_o,
    output logic       set_din_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       hdr_err_o,
    output logic       overrun_o,
    output logic [7:0] word_cnt_o
);

    localparam int unsigned MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C  = (MAX_SH > STROBE_CYCLES) ? MAX_SH : STROBE_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [14:0]     shift_q, shift_d;
    logic [CW-1:0]   phase_q, phase_d;
    logic            ser_en_q;
    logic [7:0]      data_q, data_d;
    logic [1:0]      sel_q, sel_d;
    logic [7:0]      ns_q, ns_d;
    logic            type_q, type_d;
    logic            frame_err_q, frame_err_d;
    logic            hdr_err_q, hdr_err_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      word_cnt_q, word_cnt_d;

    logic            en_rise;
    logic            bit_take;
    logic [15:0]     new_word;
    logic [7:0]      hdr;

    assign en_rise  = ser_en_i & ~ser_en_q;
    assign bit_take = ser_en_i & ser_valid_i;
    assign new_word = {shift_q, ser_bit_i};
    assign hdr      = new_word[15:8];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        data_d      = data_q;
        sel_d       = sel_q;
        ns_d        = ns_q;
        type_d      = type_q;
        frame_err_d = frame_err_q;
        hdr_err_d   = hdr_err_q;
        overrun_d   = overrun_q;
        word_cnt_d  = word_cnt_q;

        if (en_rise) begin
            frame_err_d = 1'b0;
            hdr_err_d   = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                    shift_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (!ser_en_i) begin
                    state_d   = ST_IDLE;
                    frame_err_d = frame_err_q | (bit_cnt_q != 4'd0);
                    bit_cnt_d = 4'd0;
                    shift_d   = '0;
                end else if (ser_valid_i) begin
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        shift_d   = '0;
                        // Reserved bit set, or broadcast requested on a DTC-input word.
                        if (hdr[0] || (hdr[1] && hdr[7])) begin
                            hdr_err_d = 1'b1;
                        end else begin
                            data_d  = new_word[7:0];
                            sel_d   = hdr[3:2];
                            type_d  = hdr[7];
                            ns_d    = hdr[7] ? 8'h00 : (hdr[1] ? 8'hFF : (8'd1 << hdr[6:4]));
                            phase_d = '0;
                            state_d = ST_SETUP;
                        end
                    end else begin
                        shift_d   = new_word[14:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_SETUP: begin
                if (bit_take) overrun_d = 1'b1;
                if (phase_q == CW'(SETUP_CYCLES - 1)) begin
                    phase_d    = '0;
                    state_d    = ST_STROBE;
                    word_cnt_d = word_cnt_q + 8'd1;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            ST_STROBE: begin
                if (bit_take) overrun_d = 1'b1;
                if (phase_q == CW'(STROBE_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = ST_HOLD;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (bit_take) overrun_d = 1'b1;
                if (phase_q == CW'(HOLD_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = ser_en_i ? ST_SHIFT : ST_IDLE;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            phase_q     <= '0;
            ser_en_q    <= 1'b0;
            data_q      <= 8'h00;
            sel_q       <= 2'b00;
            ns_q        <= 8'h00;
            type_q      <= 1'b0;
            frame_err_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            word_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            ser_en_q    <= ser_en_i;
            data_q      <= data_d;
            sel_q       <= sel_d;
            ns_q        <= ns_d;
            type_q      <= type_d;
            frame_err_q <= frame_err_d;
            hdr_err_q   <= hdr_err_d;
            overrun_q   <= overrun_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Outputs decode straight from registers so an async reset clears them at once.
    assign busy_o          = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign neuron_select_o = busy_o ? ns_q : 8'h00;
    assign set_data_in_o   = (state_q == ST_STROBE) && !type_q;
    assign set_din_o       = (state_q == ST_STROBE) && type_q;
    assign data_in_o       = data_q;
    assign select_o        = sel_q;
    assign frame_err_o     = frame_err_q;
    assign hdr_err_o       = hdr_err_q;
    assign overrun_o       = overrun_q;
    assign word_cnt_o      = word_cnt_q;

endmodule

// File: tb/tb_reg_frame_loader.sv
// Bench for reg_frame_loader: two instances (1/1/1 and 2/3/2 timing) share one stimulus;
// expected outputs come from a header-decoding model and a per-word cycle timeline.
module tb_reg_frame_loader;

    logic clk = 1'b0;
    logic rst_n, ser_en, ser_valid, ser_bit;
    always #5 clk = ~clk;

    logic [7:0] a_data, a_ns, a_cnt, b_data, b_ns, b_cnt;
    logic [1:0] a_sel, b_sel;
    logic       a_sdi, a_sdn, a_busy, a_ferr, a_herr, a_ovr;
    logic       b_sdi, b_sdn, b_busy, b_ferr, b_herr, b_ovr;

    reg_frame_loader dut_a (
        .clk(clk), .rst_n(rst_n), .ser_en_i(ser_en), .ser_valid_i(ser_valid), .ser_bit_i(ser_bit),
        .data_in_o(a_data), .neuron_select_o(a_ns), .select_o(a_sel), .set_data_in_o(a_sdi),
        .set_din_o(a_sdn), .busy_o(a_busy), .frame_err_o(a_ferr), .hdr_err_o(a_herr),
        .overrun_o(a_ovr), .word_cnt_o(a_cnt)
    );

    reg_frame_loader #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ser_en_i(ser_en), .ser_valid_i(ser_valid), .ser_bit_i(ser_bit),
        .data_in_o(b_data), .neuron_select_o(b_ns), .select_o(b_sel), .set_data_in_o(b_sdi),
        .set_din_o(b_sdn), .busy_o(b_busy), .frame_err_o(b_ferr), .hdr_err_o(b_herr),
        .overrun_o(b_ovr), .word_cnt_o(b_cnt)
    );

    // Observed view: selects which instance the current test is checking.
    logic       chk_b = 1'b0;
    logic [7:0] o_data, o_ns, o_cnt;
    logic [1:0] o_sel;
    logic       o_sdi, o_sdn, o_busy, o_ferr, o_herr, o_ovr;
    assign o_data = chk_b ? b_data : a_data;
    assign o_ns   = chk_b ? b_ns   : a_ns;
    assign o_cnt  = chk_b ? b_cnt  : a_cnt;
    assign o_sel  = chk_b ? b_sel  : a_sel;
    assign o_sdi  = chk_b ? b_sdi  : a_sdi;
    assign o_sdn  = chk_b ? b_sdn  : a_sdn;
    assign o_busy = chk_b ? b_busy : a_busy;
    assign o_ferr = chk_b ? b_ferr : a_ferr;
    assign o_herr = chk_b ? b_herr : a_herr;
    assign o_ovr  = chk_b ? b_ovr  : a_ovr;

    int checks = 0;
    int errors = 0;
    int cs = 1, ct = 1, ch = 1;

    logic [7:0] exp_cnt, exp_data;
    logic [1:0] exp_sel;
    logic       exp_hdr, exp_frm, exp_ovr;

    task automatic step;
        @(negedge clk);
    endtask

    function automatic logic hdr_bad(input logic [7:0] h);
        return ((h % 2) == 1) || ((((h / 2) % 2) == 1) && (h >= 128));
    endfunction

    function automatic logic [7:0] gen_valid_hdr();
        logic [7:0] h;
        h = 8'($urandom);
        h[0] = 1'b0;
        if (h[7]) h[1] = 1'b0;
        return h;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; ser_en = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0;
        step; step;
        checks++;
        if ({o_data, o_ns, o_sel, o_sdi, o_sdn, o_busy, o_ferr, o_herr, o_ovr, o_cnt} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {o_data, o_ns, o_sel, o_sdi, o_sdn, o_busy, o_ferr, o_herr, o_ovr, o_cnt});
        end
        rst_n = 1'b1;
        step;
        exp_cnt = 8'h00; exp_data = 8'h00; exp_sel = 2'b00;
        exp_hdr = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic start_frame;
        ser_en = 1'b1; ser_valid = 1'b0;
        step;
        exp_hdr = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                ser_valid = 1'b0;
                step;
            end
            ser_valid = 1'b1;
            ser_bit   = w[15-i];
            step;
        end
        ser_valid = 1'b0;
    endtask

    // Shift one word and follow its whole issue window cycle by cycle.
    task automatic run_word(input logic [7:0] hdr, input logic [7:0] data, input int gap,
                            input int ovr_at, input string tag);
        logic       typ, strobe;
        logic [1:0] sel;
        logic [7:0] ns;
        int         n;
        typ = (hdr >= 128);
        sel = 2'((hdr / 4) % 4);
        ns  = typ ? 8'h00 : ((((hdr / 2) % 2) == 1) ? 8'hFF : 8'(2 ** ((hdr / 16) % 8)));
        n   = cs + ct + ch;
        shift_bits({hdr, data}, 16, gap);
        if (hdr_bad(hdr)) begin
            exp_hdr = 1'b1;
            for (int k = 1; k <= n; k++) begin
                checks++;
                if ({o_busy, o_sdi, o_sdn, o_ns} !== 11'd0 || o_herr !== 1'b1 || o_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL %s_hdrerr k=%0d busy/sdi/sdn/ns=%b/%b/%b/%h herr=%b cnt=%0d required 0/0/0/00 herr=1 cnt=%0d",
                             tag, k, o_busy, o_sdi, o_sdn, o_ns, o_herr, o_cnt, exp_cnt);
                end
                step;
            end
            $display("txn %s hdr=%h data=%h rejected cnt=%0d", tag, hdr, data, exp_cnt);
        end else begin
            for (int k = 1; k <= n; k++) begin
                strobe = (k > cs) && (k <= cs + ct);
                if (k == cs + 1) exp_cnt = exp_cnt + 8'd1;
                checks++;
                if (o_busy !== 1'b1 || o_ns !== ns || o_data !== data || o_sel !== sel) begin
                    errors++;
                    $display("FAIL %s_fields k=%0d busy=%b ns=%h data=%h sel=%b required 1 %h %h %b",
                             tag, k, o_busy, o_ns, o_data, o_sel, ns, data, sel);
                end
                checks++;
                if (o_sdi !== (strobe && !typ) || o_sdn !== (strobe && typ) || o_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL %s_strobe k=%0d sdi=%b sdn=%b cnt=%0d required %b %b %0d",
                             tag, k, o_sdi, o_sdn, o_cnt, strobe && !typ, strobe && typ, exp_cnt);
                end
                checks++;
                if (o_ovr !== exp_ovr || o_herr !== exp_hdr) begin
                    errors++;
                    $display("FAIL %s_flags k=%0d ovr=%b herr=%b required %b %b", tag, k, o_ovr, o_herr, exp_ovr, exp_hdr);
                end
                if (k == ovr_at) begin
                    ser_valid = 1'b1;
                    ser_bit   = 1'($urandom);
                end else begin
                    ser_valid = 1'b0;
                end
                step;
                if (k == ovr_at) exp_ovr = 1'b1;
            end
            ser_valid = 1'b0;
            exp_data = data;
            exp_sel  = sel;
            checks++;
            if ({o_busy, o_sdi, o_sdn, o_ns} !== 11'd0 || o_data !== exp_data || o_sel !== exp_sel || o_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL %s_after busy/sdi/sdn/ns=%b/%b/%b/%h data=%h sel=%b cnt=%0d required 0/0/0/00 %h %b %0d",
                         tag, o_busy, o_sdi, o_sdn, o_ns, o_data, o_sel, o_cnt, exp_data, exp_sel, exp_cnt);
            end
            $display("txn %s hdr=%h data=%h issued cnt=%0d", tag, hdr, data, exp_cnt);
        end
    endtask

    task automatic test_reset;
        do_reset;
        start_frame;
        run_word(gen_valid_hdr(), 8'($urandom), 0, 0, "t1_pre");
        shift_bits(16'($urandom), 7, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_data, o_ns, o_sel, o_busy, o_ferr, o_herr, o_ovr, o_cnt} !== 33'd0) begin
            errors++;
            $display("FAIL t1_mid_shift_reset got %h required 0", {o_data, o_ns, o_sel, o_busy, o_ferr, o_herr, o_ovr, o_cnt});
        end
        step;
        rst_n = 1'b1; ser_en = 1'b0;
        step;
        exp_cnt = 8'h00; exp_data = 8'h00; exp_sel = 2'b00;
        start_frame;
        run_word(8'h38, 8'h3C, 1, 0, "t1_clean");
        // Reset while the strobe is high must drop it immediately.
        shift_bits({8'h24, 8'h99}, 16, 0);
        repeat (cs) step;
        checks++;
        if (o_sdi !== 1'b1) begin
            errors++;
            $display("FAIL t1_strobe_before_reset sdi=%b required 1", o_sdi);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_sdi !== 1'b0 || o_cnt !== 8'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_strobe_reset sdi=%b cnt=%0d busy=%b required 0 0 0", o_sdi, o_cnt, o_busy);
        end
        step;
        rst_n = 1'b1; ser_en = 1'b0;
        step;
    endtask

    task automatic test_neuron_write;
        do_reset;
        start_frame;
        run_word(8'h38, 8'hA5, 0, 0, "t2");
        for (int i = 0; i < 8; i++) run_word(gen_valid_hdr(), 8'($urandom), 2, 0, "t2_rand");
    endtask

    task automatic test_back_to_back;
        do_reset;
        start_frame;
        run_word(8'h80, 8'h5A, 0, 0, "t3_din");
        run_word(8'h02, 8'h11, 0, 0, "t3_bcast");
        run_word(8'h3C, 8'h5A, 0, 0, "t3_sel3");
    endtask

    task automatic test_hdr_err;
        logic [7:0] h;
        do_reset;
        start_frame;
        run_word(8'h01, 8'h77, 0, 0, "t4_rsv");
        run_word(8'h10, 8'hC3, 0, 0, "t4_after");
        run_word(8'h82, 8'h44, 1, 0, "t4_dinbc");
        run_word(8'h6C, 8'h0F, 0, 0, "t4_after2");
        for (int i = 0; i < 12; i++) begin
            h = 8'($urandom);
            run_word(h, 8'($urandom), 1, 0, "t4_rand");
        end
    endtask

    task automatic test_framing;
        do_reset;
        start_frame;
        shift_bits(16'($urandom), 9, 1);
        ser_en = 1'b0;
        step;
        checks++;
        if (o_ferr !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_frame_err ferr=%b busy=%b required 1 0", o_ferr, o_busy);
        end
        // Bits offered while disabled must be ignored entirely.
        for (int i = 0; i < 20; i++) begin
            ser_valid = 1'b1; ser_bit = 1'($urandom);
            step;
        end
        ser_valid = 1'b0;
        checks++;
        if (o_sdi !== 1'b0 || o_sdn !== 1'b0 || o_ovr !== 1'b0 || o_cnt !== exp_cnt || o_ferr !== 1'b1) begin
            errors++;
            $display("FAIL t5_idle sdi=%b sdn=%b ovr=%b cnt=%0d ferr=%b required 0 0 0 %0d 1",
                     o_sdi, o_sdn, o_ovr, o_cnt, o_ferr, exp_cnt);
        end
        start_frame;
        checks++;
        if (o_ferr !== 1'b0) begin
            errors++;
            $display("FAIL t5_frame_clear ferr=%b required 0", o_ferr);
        end
        run_word(gen_valid_hdr(), 8'($urandom), 0, 0, "t5_after");
        ser_en = 1'b0;
        step;
        checks++;
        if (o_ferr !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_clean_end ferr=%b busy=%b required 0 0", o_ferr, o_busy);
        end
    endtask

    task automatic test_overrun;
        chk_b = 1'b1; cs = 2; ct = 3; ch = 2;
        do_reset;
        start_frame;
        run_word(gen_valid_hdr(), 8'($urandom), 0, 4, "t6_ovr");
        run_word(gen_valid_hdr(), 8'($urandom), 1, 0, "t6_next");
        for (int i = 0; i < 4; i++)
            run_word(gen_valid_hdr(), 8'($urandom), 1, $urandom_range(cs + ct + ch, 1), "t6_rand");
        ser_en = 1'b0;
        step;
        start_frame;
        checks++;
        if (o_ovr !== 1'b0) begin
            errors++;
            $display("FAIL t6_ovr_clear ovr=%b required 0", o_ovr);
        end
        run_word(8'h80, 8'hE1, 0, 0, "t6_din");
        chk_b = 1'b0; cs = 1; ct = 1; ch = 1;
    endtask

    task automatic test_wrap;
        do_reset;
        start_frame;
        for (int i = 0; i < 257; i++) run_word(gen_valid_hdr(), 8'($urandom), 0, 0, "wrap");
        checks++;
        if (o_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_cnt got %0d required 1", o_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0; ser_en = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0;
        test_reset;
        test_neuron_write;
        test_back_to_back;
        test_hdr_err;
        test_framing;
        test_overrun;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
